par8_bus_if: RTL and testbench
==============================

// Module: par8_bus_if
// PURPOSE
//  Pi-side byte link for the MD5 accelerator: terminates the Raspberry Pi 8-bit parallel bus
//  (bus_clk strobe, bidirectional bus_data, bus_rnw) inside the FPGA clk domain.
//  Write bytes from the Pi are synchronised and buffered in an RX FIFO, then handed to the
//  command/hash logic over a valid/ready stream. Result bytes from that logic are presented on
//  bus_data for Pi reads. Sits between the board pins and the md5 core/command decoder.
// PARAMETERS
//  RX_AW     4  log2 RX FIFO depth (16 entries)
//  SYNC_LEN  2  synchroniser flops on bus_clk, bus_rnw and bus_data (>=2)
// PORTS
//  clk          in     1  system clock (100 MHz); all logic on its rising edge
//  reset_n      in     1  asynchronous active-low reset
//  bus_clk      in     1  Pi strobe; asynchronous to clk; a transfer completes on its rising edge
//  bus_data     inout  8  Pi data bus; FPGA drives it only in read mode, else high-Z
//  bus_rnw      in     1  1 = Pi reads (FPGA drives), 0 = Pi writes (Pi's perspective)
//  rx_data      out    8  head byte of the RX FIFO
//  rx_valid     out    1  RX FIFO not empty
//  rx_ready     in     1  consumer pops the head when rx_valid & rx_ready
//  tx_data      in     8  next byte for the Pi to read
//  tx_valid     in     1  tx_data is valid
//  tx_ready     out    1  byte accepted when tx_valid & tx_ready
//  rx_overflow  out    1  sticky: a write strobe arrived while the FIFO was full
//  tx_underrun  out    1  sticky: a read strobe completed with the hold register empty
//  clr_status   in     1  synchronous clear of both sticky flags
// BEHAVIOUR
//  Reset values (async, reset_n=0): bus_data high-Z, rx_valid=0, rx_data=8'h00,
//   tx_ready=1, rx_overflow=0, tx_underrun=0, FIFO pointers=0, sync chains=0, hold empty.
//  Sync: bus_clk, bus_rnw and bus_data each pass through SYNC_LEN flops. A third flop on
//   bus_clk gives clk_d. Strobe edge: rise = clk_s & ~clk_d, one clk cycle wide.
//   Only rising edges count; falling edges are ignored.
//  Write (rnw_s=0 at rise): data_s is pushed into the FIFO on the same clk edge.
//   rx_valid is high after the 4th clk edge that samples bus_clk=1 (SYNC_LEN=2).
//   The Pi must hold bus_data stable from before its rising edge until >=4 clk cycles after it.
//  FIFO: 2**RX_AW x 8, first-word fall-through. Pointers are RX_AW+1 bits wide.
//   empty when the pointers are equal; full when the MSBs differ and the rest match.
//   Wrap-around is natural modulo.
//   Push and pop in the same cycle are both honoured; count is unchanged, even when full.
//   Push while full and no pop: byte dropped, rx_overflow<=1, FIFO contents untouched.
//  Read mode: drive_en <= rnw_s registered. bus_data = drive_en ? out_byte : 8'hzz.
//   The Pi must wait >=4 clk cycles after raising bus_rnw before sampling bus_data.
//   out_byte = hold_data when hold full, else 8'h00.
//  Hold register: tx_ready = ~hold_full | pop, where pop = rise & rnw_s.
//   tx_valid & tx_ready loads hold_data; pop and load in the same cycle move straight to the new byte.
//   pop with hold empty: tx_underrun<=1, nothing changes.
//  Rise with rnw_s=1 never pushes the FIFO; rise with rnw_s=0 never pops the hold register.
//   bus_rnw changing mid-strobe is judged by rnw_s in the rise cycle only.
//  clr_status clears the flags; a set event in the same cycle wins (flag stays 1).
//  reset_n asserted mid-transfer: bus released immediately (async); FIFO and hold contents discarded.
// TESTING
//  T1 Pi writes 8'hA5, 8'h3C with rx_ready=1 -> rx stream shows A5, then 3C.
//     Each rx_valid appears 4 clk edges after its strobe rise.
//  T2 17 writes with rx_ready=0 -> FIFO full with bytes 1..16; 17th dropped; rx_overflow=1.
//     Then drain -> exactly 16 bytes in order. clr_status -> flag 0.
//  T3 FIFO full plus a write rise coinciding with a pop -> count stays 16, no overflow.
//     New byte appears last.
//  T4 tx_data 8'h11, 8'h22 offered, bus_rnw=1, two read strobes -> Pi samples 11 then 22.
//     Third strobe with tx_valid=0 -> bus shows 00, tx_underrun=1.
//  T5 Toggle bus_rnw 0->1->0 -> bus_data high-Z except while drive_en.
//     No FIFO push or hold pop without a strobe rise.
//  T6 Assert reset_n low mid-stream with 5 bytes buffered and bus driven.
//     -> bus_data high-Z immediately, rx_valid=0, tx_ready=1, flags 0.

Source files
------------

// File: rtl/par8_bus_if_if.sv
// Byte-stream side of the Pi parallel link: RX stream out, TX stream in, sticky status.
interface par8_bus_if_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_overflow;
    logic       tx_underrun;
    logic       clr_status;

    modport slave (
        output rx_data, rx_valid, tx_ready, rx_overflow, tx_underrun,
        input  rx_ready, tx_data, tx_valid, clr_status
    );

    modport master (
        input  rx_data, rx_valid, tx_ready, rx_overflow, tx_underrun,
        output rx_ready, tx_data, tx_valid, clr_status
    );
endinterface

// File: rtl/par8_bus_if.sv
// Raspberry Pi 8-bit parallel bus terminator: synchronises the Pi strobe into clk,
// buffers written bytes in an RX FIFO and serves read bytes from a one-entry hold register.
module par8_bus_if #(
    parameter int RX_AW    = 4,
    parameter int SYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_clk,
    inout  wire  [7:0]  bus_data,
    input  logic        bus_rnw,
    par8_bus_if_if.slave sif
);

    localparam int DEPTH = 1 << RX_AW;

    logic [SYNC_LEN-1:0] clk_sync_q;
    logic [SYNC_LEN-1:0] rnw_sync_q;
    logic [7:0]          data_sync_q [SYNC_LEN];
    logic                clk_d_q;

    logic       clk_s;
    logic       rnw_s;
    logic [7:0] data_s;
    logic       rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '0;
            rnw_sync_q <= '0;
            clk_d_q    <= 1'b0;
            for (int i = 0; i < SYNC_LEN; i++) data_sync_q[i] <= 8'h00;
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_LEN-2:0], bus_clk};
            rnw_sync_q     <= {rnw_sync_q[SYNC_LEN-2:0], bus_rnw};
            clk_d_q        <= clk_sync_q[SYNC_LEN-1];
            data_sync_q[0] <= bus_data;
            for (int i = 1; i < SYNC_LEN; i++) data_sync_q[i] <= data_sync_q[i-1];
        end
    end

    assign clk_s  = clk_sync_q[SYNC_LEN-1];
    assign rnw_s  = rnw_sync_q[SYNC_LEN-1];
    assign data_s = data_sync_q[SYNC_LEN-1];
    assign rise   = clk_s & ~clk_d_q;

    logic push_req;
    logic pop_tx;
    assign push_req = rise & ~rnw_s;
    assign pop_tx   = rise &  rnw_s;

    logic [7:0]     mem [DEPTH];
    logic [RX_AW:0] wr_ptr_q, wr_ptr_d;
    logic [RX_AW:0] rd_ptr_q, rd_ptr_d;
    logic           rx_valid_q, rx_valid_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           fifo_full;
    logic           rx_pop;
    logic           push_ok;
    logic           overflow_set;

    assign fifo_full = (wr_ptr_q[RX_AW] != rd_ptr_q[RX_AW]) &&
                       (wr_ptr_q[RX_AW-1:0] == rd_ptr_q[RX_AW-1:0]);
    assign rx_pop       = sif.rx_ready & rx_valid_q;
    assign push_ok      = push_req & (~fifo_full | rx_pop);
    assign overflow_set = push_req & fifo_full & ~rx_pop;

    // Output stage looks at the next read pointer but the current write pointer, so a pop
    // advances the head immediately while a fresh push shows up one cycle later.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + (RX_AW+1)'(push_ok);
        rd_ptr_d   = rd_ptr_q + (RX_AW+1)'(rx_pop);
        rx_valid_d = (wr_ptr_q != rd_ptr_d);
        rx_data_d  = 8'h00;
        if (rx_valid_d) rx_data_d = mem[rd_ptr_d[RX_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[RX_AW-1:0]] <= data_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign sif.rx_valid = rx_valid_q;
    assign sif.rx_data  = rx_data_q;

    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       tx_ready;
    logic       tx_load;
    logic       underrun_set;

    assign tx_ready     = ~hold_full_q | pop_tx;
    assign tx_load      = sif.tx_valid & tx_ready;
    assign underrun_set = pop_tx & ~hold_full_q;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (pop_tx && hold_full_q) hold_full_d = 1'b0;
        if (tx_load) begin
            hold_full_d = 1'b1;
            hold_data_d = sif.tx_data;
        end
    end

    logic ovf_q, ovf_d;
    logic unr_q, unr_d;
    assign ovf_d = overflow_set | (ovf_q & ~sif.clr_status);
    assign unr_d = underrun_set | (unr_q & ~sif.clr_status);

    logic drive_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full_q <= 1'b0;
            hold_data_q <= 8'h00;
            ovf_q       <= 1'b0;
            unr_q       <= 1'b0;
            drive_en_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            ovf_q       <= ovf_d;
            unr_q       <= unr_d;
            drive_en_q  <= rnw_s;
        end
    end

    assign sif.tx_ready    = tx_ready;
    assign sif.rx_overflow = ovf_q;
    assign sif.tx_underrun = unr_q;

    logic [7:0] out_byte;
    assign out_byte = hold_full_q ? hold_data_q : 8'h00;
    assign bus_data = drive_en_q ? out_byte : 8'hzz;

endmodule

// File: tb/tb_par8_bus_if.sv
// Directed bench for par8_bus_if: Pi write/read strobes, FIFO limits, hold register, reset.
module tb_par8_bus_if;
    logic       clk;
    logic       reset_n;
    logic       bus_clk;
    logic       bus_rnw;
    logic       pi_drv;
    logic [7:0] pi_data;
    wire  [7:0] bus_data;
    int         vecs;
    int         errs;

    par8_bus_if_if sif();

    par8_bus_if #(.RX_AW(4), .SYNC_LEN(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus_clk  (bus_clk),
        .bus_data (bus_data),
        .bus_rnw  (bus_rnw),
        .sif      (sif)
    );

    assign bus_data = pi_drv ? pi_data : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic pi_write(input logic [7:0] b);
        @(negedge clk);
        pi_data = b;
        pi_drv  = 1'b1;
        bus_clk = 1'b1;
        repeat (5) @(negedge clk);
        bus_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus_clk = 1'b0; bus_rnw = 1'b0; pi_drv = 1'b1; pi_data = 8'h00;
        sif.rx_ready = 1'b0; sif.tx_data = 8'h00; sif.tx_valid = 1'b0; sif.clr_status = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (sif.rx_valid !== 1'b0) begin errs++; $display("FAIL rst_rx_valid: got %b want 0", sif.rx_valid); end
        vecs++; if (sif.rx_data !== 8'h00) begin errs++; $display("FAIL rst_rx_data: got %h want 00", sif.rx_data); end
        vecs++; if (sif.tx_ready !== 1'b1) begin errs++; $display("FAIL rst_tx_ready: got %b want 1", sif.tx_ready); end
        vecs++; if ({sif.rx_overflow, sif.tx_underrun} !== 2'b00) begin errs++; $display("FAIL rst_flags: got %b want 00", {sif.rx_overflow, sif.tx_underrun}); end
        vecs++; if (dut.drive_en_q !== 1'b0) begin errs++; $display("FAIL rst_drive: got %b want 0", dut.drive_en_q); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (sif.rx_valid !== 1'b0) begin errs++; $display("FAIL rst_rel_rx_valid: got %b want 0", sif.rx_valid); end
    endtask

    task automatic test_write_latency();
        logic [7:0] bytes [2];
        int  n;
        bit  got;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C;
        sif.rx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            pi_data = bytes[k];
            bus_clk = 1'b1;
            n = 0; got = 0;
            while (n < 10 && !got) begin
                @(posedge clk); #1;
                n++;
                if (sif.rx_valid) got = 1;
            end
            vecs++; if (n !== 4) begin errs++; $display("FAIL wr_latency[%0d]: got %0d edges want 4", k, n); end
            vecs++; if (sif.rx_data !== bytes[k]) begin errs++; $display("FAIL wr_data[%0d]: got %h want %h", k, sif.rx_data, bytes[k]); end
            repeat (3) @(negedge clk);
            bus_clk = 1'b0;
            repeat (4) @(negedge clk);
            vecs++; if (sif.rx_valid !== 1'b0) begin errs++; $display("FAIL wr_popped[%0d]: got %b want 0", k, sif.rx_valid); end
        end
        sif.rx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) pi_write(8'(i));
        vecs++; if (sif.rx_overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", sif.rx_overflow); end
        vecs++; if (sif.rx_data !== 8'h01) begin errs++; $display("FAIL ovf_head: got %h want 01", sif.rx_data); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vecs++; if (sif.rx_valid !== 1'b1 || sif.rx_data !== 8'(i)) begin errs++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, sif.rx_valid, sif.rx_data, 8'(i)); end
            sif.rx_ready = 1'b1;
        end
        @(negedge clk);
        sif.rx_ready = 1'b0;
        vecs++; if (sif.rx_valid !== 1'b0) begin errs++; $display("FAIL ovf_empty: got %b want 0", sif.rx_valid); end
        sif.clr_status = 1'b1;
        @(negedge clk);
        sif.clr_status = 1'b0;
        vecs++; if (sif.rx_overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr: got %b want 0", sif.rx_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 1; i <= 16; i++) pi_write(8'(i));
        vecs++; if (sif.rx_data !== 8'h01) begin errs++; $display("FAIL fp_head: got %h want 01", sif.rx_data); end
        @(negedge clk);
        pi_data = 8'hEE;
        bus_clk = 1'b1;
        repeat (2) @(negedge clk);
        sif.rx_ready = 1'b1;
        @(negedge clk);
        sif.rx_ready = 1'b0;
        vecs++; if (sif.rx_overflow !== 1'b0) begin errs++; $display("FAIL fp_no_ovf: got %b want 0", sif.rx_overflow); end
        vecs++; if (sif.rx_data !== 8'h02) begin errs++; $display("FAIL fp_newhead: got %h want 02", sif.rx_data); end
        repeat (2) @(negedge clk);
        bus_clk = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(i + 2) : 8'hEE;
            @(negedge clk);
            vecs++; if (sif.rx_valid !== 1'b1 || sif.rx_data !== exp) begin errs++; $display("FAIL fp_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, sif.rx_valid, sif.rx_data, exp); end
            sif.rx_ready = 1'b1;
        end
        @(negedge clk);
        sif.rx_ready = 1'b0;
        vecs++; if (sif.rx_valid !== 1'b0) begin errs++; $display("FAIL fp_empty: got %b want 0", sif.rx_valid); end
    endtask

    task automatic test_read();
        int n;
        bit loaded;
        @(negedge clk);
        pi_drv  = 1'b0;
        bus_rnw = 1'b1;
        repeat (5) @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b1 || bus_data !== 8'h00) begin errs++; $display("FAIL rd_idle: got en=%b d=%h want en=1 d=00", dut.drive_en_q, bus_data); end
        sif.tx_data = 8'h11; sif.tx_valid = 1'b1;
        vecs++; if (sif.tx_ready !== 1'b1) begin errs++; $display("FAIL rd_ready_empty: got %b want 1", sif.tx_ready); end
        @(negedge clk);
        sif.tx_data = 8'h22;
        vecs++; if (sif.tx_ready !== 1'b0) begin errs++; $display("FAIL rd_ready_full: got %b want 0", sif.tx_ready); end
        vecs++; if (bus_data !== 8'h11) begin errs++; $display("FAIL rd_byte1: got %h want 11", bus_data); end
        bus_clk = 1'b1;
        n = 0; loaded = 0;
        while (n < 8 && !loaded) begin
            @(negedge clk);
            n++;
            if (sif.tx_ready) begin
                @(negedge clk);
                loaded = 1;
            end
        end
        sif.tx_valid = 1'b0;
        vecs++; if (n !== 2 || !loaded) begin errs++; $display("FAIL rd_pop_time: got %0d want 2", n); end
        vecs++; if (bus_data !== 8'h22) begin errs++; $display("FAIL rd_byte2: got %h want 22", bus_data); end
        bus_clk = 1'b0;
        repeat (4) @(negedge clk);
        bus_clk = 1'b1;
        repeat (4) @(negedge clk);
        vecs++; if (bus_data !== 8'h00 || sif.tx_ready !== 1'b1) begin errs++; $display("FAIL rd_after2: got d=%h rdy=%b want d=00 rdy=1", bus_data, sif.tx_ready); end
        vecs++; if (sif.tx_underrun !== 1'b0) begin errs++; $display("FAIL rd_no_unr: got %b want 0", sif.tx_underrun); end
        bus_clk = 1'b0;
        repeat (4) @(negedge clk);
        bus_clk = 1'b1;
        repeat (4) @(negedge clk);
        vecs++; if (sif.tx_underrun !== 1'b1 || bus_data !== 8'h00) begin errs++; $display("FAIL rd_underrun: got unr=%b d=%h want unr=1 d=00", sif.tx_underrun, bus_data); end
        bus_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rnw_toggle();
        @(negedge clk);
        bus_rnw = 1'b0;
        repeat (5) @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b0) begin errs++; $display("FAIL tg_released: got %b want 0", dut.drive_en_q); end
        pi_drv = 1'b1; pi_data = 8'h5A;
        sif.tx_data = 8'h77; sif.tx_valid = 1'b1;
        @(negedge clk);
        sif.tx_valid = 1'b0;
        pi_drv  = 1'b0;
        bus_rnw = 1'b1;
        @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b0) begin errs++; $display("FAIL tg_early: got %b want 0", dut.drive_en_q); end
        repeat (2) @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b1 || bus_data !== 8'h77) begin errs++; $display("FAIL tg_drive: got en=%b d=%h want en=1 d=77", dut.drive_en_q, bus_data); end
        bus_rnw = 1'b0;
        @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b1) begin errs++; $display("FAIL tg_hold: got %b want 1", dut.drive_en_q); end
        repeat (3) @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b0) begin errs++; $display("FAIL tg_release2: got %b want 0", dut.drive_en_q); end
        pi_drv = 1'b1;
        vecs++; if (sif.tx_ready !== 1'b0 || sif.rx_valid !== 1'b0) begin errs++; $display("FAIL tg_no_xfer: got rdy=%b rxv=%b want rdy=0 rxv=0", sif.tx_ready, sif.rx_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) pi_write(8'(8'h40 + i));
        vecs++; if (sif.rx_valid !== 1'b1 || sif.rx_data !== 8'h40) begin errs++; $display("FAIL mr_buffered: got v=%b d=%h want v=1 d=40", sif.rx_valid, sif.rx_data); end
        pi_drv  = 1'b0;
        bus_rnw = 1'b1;
        repeat (5) @(negedge clk);
        vecs++; if (dut.drive_en_q !== 1'b1 || bus_data !== 8'h77) begin errs++; $display("FAIL mr_driving: got en=%b d=%h want en=1 d=77", dut.drive_en_q, bus_data); end
        bus_clk = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vecs++; if (dut.drive_en_q !== 1'b0) begin errs++; $display("FAIL mr_release: got %b want 0", dut.drive_en_q); end
        vecs++; if (sif.rx_valid !== 1'b0 || sif.tx_ready !== 1'b1) begin errs++; $display("FAIL mr_streams: got rxv=%b rdy=%b want rxv=0 rdy=1", sif.rx_valid, sif.tx_ready); end
        vecs++; if ({sif.rx_overflow, sif.tx_underrun} !== 2'b00) begin errs++; $display("FAIL mr_flags: got %b want 00", {sif.rx_overflow, sif.tx_underrun}); end
        bus_clk = 1'b0; bus_rnw = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        vecs++; if (sif.rx_valid !== 1'b0 || sif.rx_data !== 8'h00) begin errs++; $display("FAIL mr_discarded: got v=%b d=%h want v=0 d=00", sif.rx_valid, sif.rx_data); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_write_latency();
        test_overflow();
        test_full_push_pop();
        test_read();
        test_rnw_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
